// File: rtl/dbus_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_dma_pkg
// Description : Shared types and constants for the dbus block-copy initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Bank field occupies the top c_BANK_W bits of a bus address.
    localparam int                  c_BANK_W = 3;
    localparam logic [c_BANK_W-1:0] c_RAM_BK = 3'd0;
    localparam logic [c_BANK_W-1:0] c_IO_BK  = 3'd1;

endpackage
`default_nettype wire

// File: rtl/dbus_dma.sv
`default_nettype none
// ============================================================================
// Module      : dbus_dma
// Description : Block-copy bus initiator on the data bus. Optional fill mode
//               is enabled by defining DBUS_DMA_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_dma
    import dbus_dma_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] len,
`ifdef DBUS_DMA_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_val,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    output logic          m_we,
    input  logic [DW-1:0] m_dout
);

    localparam logic [AW-1:0] c_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        r_state_q, w_state_d;
    logic [AW-1:0] r_sp_q,    w_sp_d;
    logic [AW-1:0] r_dp_q,    w_dp_d;
    logic [AW-1:0] r_cnt_q,   w_cnt_d;
    logic          r_busy_q,  w_busy_d;
    logic          r_done_q,  w_done_d;
    logic          r_we_q,    w_we_d;
    logic [AW-1:0] r_addr_q,  w_addr_d;

    logic          w_fill_mode;
    logic          w_start_fill;
    logic [DW-1:0] w_wr_data;

`ifdef DBUS_DMA_FILL_EN
    logic          r_fill_q,     w_fill_d;
    logic [DW-1:0] r_fill_val_q, w_fill_val_d;

    assign w_fill_mode  = r_fill_q;
    assign w_start_fill = fill;
    assign w_wr_data    = r_fill_q ? r_fill_val_q : m_dout;
`else
    assign w_fill_mode  = 1'b0;
    assign w_start_fill = 1'b0;
    assign w_wr_data    = m_dout;
`endif

    // Bus outputs are registered one cycle ahead, so they are computed from
    // the state being entered rather than the current one.
    always_comb begin
        w_state_d = r_state_q;
        w_sp_d    = r_sp_q;
        w_dp_d    = r_dp_q;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;
        w_we_d    = 1'b0;
        w_addr_d  = '0;
`ifdef DBUS_DMA_FILL_EN
        w_fill_d     = r_fill_q;
        w_fill_val_d = r_fill_val_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_sp_d  = src_base;
                    w_dp_d  = dst_base;
                    w_cnt_d = len;
`ifdef DBUS_DMA_FILL_EN
                    w_fill_d     = fill;
                    w_fill_val_d = fill_val;
`endif
                    if (len == '0) begin
                        w_state_d = ST_FIN;
                        w_done_d  = 1'b1;
                    end else if (w_start_fill) begin
                        w_state_d = ST_WR;
                        w_busy_d  = 1'b1;
                        w_we_d    = 1'b1;
                        w_addr_d  = dst_base;
                    end else begin
                        w_state_d = ST_RD;
                        w_busy_d  = 1'b1;
                        w_addr_d  = src_base;
                    end
                end
            end
            ST_RD: begin
                w_state_d = ST_WR;
                w_busy_d  = 1'b1;
                w_we_d    = 1'b1;
                w_addr_d  = r_dp_q;
            end
            ST_WR: begin
                w_sp_d  = r_sp_q + c_ONE;
                w_dp_d  = r_dp_q + c_ONE;
                w_cnt_d = r_cnt_q - c_ONE;
                if (r_cnt_q == c_ONE) begin
                    w_state_d = ST_FIN;
                    w_done_d  = 1'b1;
                end else if (w_fill_mode) begin
                    w_state_d = ST_WR;
                    w_busy_d  = 1'b1;
                    w_we_d    = 1'b1;
                    w_addr_d  = r_dp_q + c_ONE;
                end else begin
                    w_state_d = ST_RD;
                    w_busy_d  = 1'b1;
                    w_addr_d  = r_sp_q + c_ONE;
                end
            end
            ST_FIN: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_sp_q    <= '0;
            r_dp_q    <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
`ifdef DBUS_DMA_FILL_EN
            r_fill_q     <= 1'b0;
            r_fill_val_q <= '0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_sp_q    <= w_sp_d;
            r_dp_q    <= w_dp_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
`ifdef DBUS_DMA_FILL_EN
            r_fill_q     <= w_fill_d;
            r_fill_val_q <= w_fill_val_d;
`endif
        end
    end

    // Write data follows the bus read data in the same cycle; the 1-cycle
    // read latency places the RD result on m_dout exactly during WR.
    always_comb begin
        m_din = '0;
        if (r_state_q == ST_WR) begin
            m_din = w_wr_data;
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign m_we   = r_we_q;
    assign m_addr = r_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dbus_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_dma
// Description : Randomized scoreboard bench for dbus_dma with a bus RAM model.
//               Fill-mode cases compile in when DBUS_DMA_FILL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_base = '0;
    logic [15:0] dst_base = '0;
    logic [15:0] len = '0;
`ifdef DBUS_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [15:0] fill_val = '0;
`endif
    logic        busy, done, m_we;
    logic [15:0] m_addr, m_din, m_dout;

    always #5 clk = ~clk;

    dbus_dma #(.DW(16), .AW(16)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .len      (len),
`ifdef DBUS_DMA_FILL_EN
        .fill     (fill),
        .fill_val (fill_val),
`endif
        .busy     (busy),
        .done     (done),
        .m_addr   (m_addr),
        .m_din    (m_din),
        .m_we     (m_we),
        .m_dout   (m_dout)
    );

    // Bus RAM with registered read (1-cycle latency) and a preload port.
    logic [15:0] ram     [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit          mem_init = 1'b0;
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= ref_mem[i];
            mem_init <= 1'b1;
        end else if (pl_we) begin
            ram[pl_addr] <= pl_data;
        end else if (m_we) begin
            ram[m_addr] <= m_din;
        end
        m_dout <= ram[m_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int busy_cnt = 0;

    logic [15:0] exp_rd[$];
    logic [31:0] exp_wr[$];
    int          exp_done_cyc[$];
    int          exp_busy[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endfunction

    function automatic void fail_now(string name, logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h, expected none (cyc %0d)", name, act, cyc);
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (m_we) begin
                if (exp_wr.size() == 0) fail_now("unexpected_write", {m_addr, m_din});
                else chk("write_addr_data", {m_addr, m_din}, exp_wr.pop_front());
            end else if (busy) begin
                if (exp_rd.size() == 0) fail_now("unexpected_read", {16'h0, m_addr});
                else chk("read_addr", {16'h0, m_addr}, {16'h0, exp_rd.pop_front()});
            end
            if (done) begin
                if (exp_done_cyc.size() == 0) begin
                    fail_now("unexpected_done", cyc);
                end else begin
                    chk("done_cycle", cyc, exp_done_cyc.pop_front());
                    chk("busy_cycles", busy_cnt, exp_busy.pop_front());
                    chk("busy_at_done", {31'h0, busy}, 32'h0);
                end
                busy_cnt = 0;
            end
            if (!rst) busy_cnt = 0;
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Reference: sequential ascending copy/fill of n_do words; the expected
    // bus reads, writes and done timing are queued for the monitor.
    task automatic issue(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] n, input bit fl, input logic [15:0] fv,
                         input int n_do, input bit want_done);
        int t;
        logic [15:0] sa, da, d;
        @(posedge clk); #1;
        t = cyc + 1;
        src_base = src; dst_base = dst; len = n; start = 1'b1;
`ifdef DBUS_DMA_FILL_EN
        fill = fl; fill_val = fv;
`endif
        for (int i = 0; i < n_do; i++) begin
            sa = src + 16'(i);
            da = dst + 16'(i);
            d  = fl ? fv : ref_mem[sa];
            if (!fl) exp_rd.push_back(sa);
            exp_wr.push_back({da, d});
            ref_mem[da] = d;
        end
        if (want_done) begin
            exp_done_cyc.push_back(fl ? t + int'(n) : t + 2 * int'(n));
            exp_busy.push_back(fl ? int'(n) : 2 * int'(n));
        end
        @(posedge clk); #1;
        start = 1'b0;
        src_base = 16'($urandom); dst_base = 16'($urandom); len = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_done_cyc.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            fail_now("timeout_pending", exp_wr.size() + exp_rd.size() + exp_done_cyc.size());
            exp_wr.delete(); exp_rd.delete(); exp_done_cyc.delete(); exp_busy.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_region(input logic [15:0] base, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            chk("ram_word", {16'h0, ram[a]}, {16'h0, ref_mem[a]});
        end
    endtask

    initial begin
        logic [15:0] s, d, n;
        bit fl;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'($urandom);
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'h0, busy}, 32'h0);
        chk("reset_done",   {31'h0, done}, 32'h0);
        chk("reset_we",     {31'h0, m_we}, 32'h0);
        chk("reset_addr",   {16'h0, m_addr}, 32'h0);
        chk("reset_din",    {16'h0, m_din}, 32'h0);
        rst = 1'b1;

        // Basic copy of a known pattern.
        for (int i = 0; i < 4; i++) preload(16'h0010 + 16'(i), 16'(i + 1));
        issue(16'h0010, 16'h0040, 16'd4, 1'b0, 16'h0, 4, 1'b1);
        wait_idle(40);
        for (int i = 0; i < 4; i++) chk("copy_pattern", {16'h0, ram[16'h0040 + 16'(i)]}, 32'(i + 1));

        // Zero length: done only, no bus activity.
        issue(16'h1234, 16'h5678, 16'd0, 1'b0, 16'h0, 0, 1'b1);
        wait_idle(20);

        // Bank crossing and 16-bit wrap of the source pointer.
        issue(16'h1FFE, 16'h0100, 16'd4, 1'b0, 16'h0, 4, 1'b1);
        wait_idle(40);
        check_region(16'h0100, 4);
        issue(16'hFFFF, 16'h0200, 16'd3, 1'b0, 16'h0, 3, 1'b1);
        wait_idle(40);
        check_region(16'h0200, 3);

        // Overlapping range dst = src + 1 replicates the first word.
        issue(16'h0300, 16'h0301, 16'd4, 1'b0, 16'h0, 4, 1'b1);
        wait_idle(40);
        check_region(16'h0300, 5);

        // Start pulsed during WR is ignored.
        issue(16'h0400, 16'h0500, 16'd3, 1'b0, 16'h0, 3, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; src_base = 16'h0900; dst_base = 16'h0A00; len = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(40);
        repeat (4) @(posedge clk);
        check_region(16'h0500, 3);

        // Reset during the second WR of a 5-word copy.
        issue(16'h0600, 16'h0700, 16'd5, 1'b0, 16'h0, 2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_we",   {31'h0, m_we}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_addr", {16'h0, m_addr}, 32'h0);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_pending_writes", exp_wr.size(), 0);
        check_region(16'h0700, 5);

`ifdef DBUS_DMA_FILL_EN
        issue(16'h0000, 16'h0020, 16'd3, 1'b1, 16'hA5A5, 3, 1'b1);
        wait_idle(30);
        for (int i = 0; i < 3; i++) chk("fill_pattern", {16'h0, ram[16'h0020 + 16'(i)]}, 32'h0000A5A5);
`endif

        // Randomized transfers, some near the top of the address space.
        for (int k = 0; k < 14; k++) begin
            s = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 4)) : 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? s + 16'($urandom_range(0, 3)) : 16'($urandom);
            n = 16'($urandom_range(0, 6));
            fl = 1'b0;
`ifdef DBUS_DMA_FILL_EN
            fl = ($urandom_range(0, 2) == 0);
`endif
            issue(s, d, n, fl, 16'($urandom), int'(n), 1'b1);
            wait_idle(60);
            check_region(d, int'(n));
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbus_dma.md
# dbus_dma

Block-copy bus initiator for the data bus (`dbus`). On a start pulse it reads `len` consecutive words from `src_base` and writes them to `dst_base`, driving the same `addr`/`din`/`we`/`dout` signal set that the data-bus decoder accepts. It sits beside the core as a second initiator; the external arbitration mux grants the bus while `busy` is high.

## Interface
- `DW`, 16, data width
- `AW`, 16, address width; top 3 bits select the bus bank
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `src_base`  in  AW  first source word address; sampled with `start`
- `dst_base`  in  AW  first destination word address; sampled with `start`
- `len`  in  AW  word count; sampled with `start`; 0 is legal
- `busy`  out  1  high while a transfer owns the bus
- `done`  out  1  one-cycle completion pulse
- `m_addr`  out  AW  bus address
- `m_din`  out  DW  bus write data
- `m_we`  out  1  bus write enable, active high
- `m_dout`  in  DW  bus read data; valid one cycle after its address
- `fill`, `fill_val`  in  1, DW  present only with `DBUS_DMA_FILL_EN`

## Operation
- FSM states: IDLE, RD, WR, FIN.
- IDLE: `start`=1 latches `src_base`, `dst_base` and `len` into `sp`, `dp` and `cnt`. If `len`=0 the next state is FIN; otherwise it is RD.
- RD: `m_addr`=`sp`, `m_we`=0. The next state is WR.
- WR: `m_addr`=`dp`, `m_we`=1, `m_din`=`m_dout`. `m_din` is combinational pass-through of `m_dout`; there is no capture register.
  - Also in WR: `sp`+=1, `dp`+=1, `cnt`-=1.
  - If `cnt`=1 before the decrement, the next state is FIN; otherwise it is RD.
- FIN: `done`=1 and `busy`=0. The next state is IDLE unconditionally.
- `busy` is high in RD and WR only.
- Address arithmetic is modulo 2^AW. 16'hFFFF+1 wraps to 16'h0000, and the wrap crosses banks with no special handling.
- `start` in any state other than IDLE is ignored. It is neither queued nor an error.
- Overlapping ranges are copied in ascending address order with no hazard handling. For example, dst=src+1 replicates the first word.
- Outputs outside RD/WR are `m_addr`=0, `m_din`=0 and `m_we`=0.

## Timing
- Reset (`rst`=0 at a clock edge) sets the state to IDLE and sets `busy`=0, `done`=0, `m_we`=0, `m_addr`=0, `m_din`=0, `sp`=`dp`=`cnt`=0.
- Reset asserted mid-transfer aborts on that edge. No further write is issued and no `done` pulse is generated.
- Start at edge T (copy mode):
  - RD occupies cycle T+1.
  - The first WR occupies T+2.
  - Each word takes 2 cycles.
  - FIN occupies T+1+2·len.
  - `start` can be accepted again at edge T+2+2·len.
- `len`=0: FIN at T+1, so `done` is high during cycle T+1. The bus is never driven.
- Each write sees read data from the immediately preceding RD cycle. This relies on the fixed 1-cycle bus read latency.

## Configuration
- `DBUS_DMA_FILL_EN` defined:
  - Adds the `fill` and `fill_val` ports. Both are sampled with `start`.
  - When the latched `fill`=1, RD is skipped. The FSM stays in WR for `len` cycles with `m_din`=`fill_val`, then goes to FIN.
  - Fill mode costs 1 cycle per word.
- Macro undefined: the ports are absent, and only copy mode exists.

## Structure
- Shared package `dbus_dma_pkg` holds:
  - the state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2, FIN=2'd3);
  - the bank-field width constant (3);
  - bank numbers RAM_BK=0 and IO_BK=1, for benches.
- No sub-module. The FSM and the three counters form one module.

## Test plan
- Reset, then copy src=16'h0010, dst=16'h0040, len=4 with RAM preloaded 1,2,3,4 → RAM[0x40..0x43]=1,2,3,4; `done` high at T+9; `busy` high for 8 cycles.
- len=0 → `done` at T+1; `m_we` never 1; `busy` never high.
- src=16'h1FFE, dst=16'h0100, len=4 → reads 1FFE, 1FFF, 2000, 2001 (bank 0→1 crossing), writes 0100–0103. A second run with src=16'hFFFF wraps to 0000.
- `start` pulsed during WR of a len=3 transfer → ignored; exactly 3 writes; one `done`.
- `rst`=0 in the second WR of len=5 → next cycle IDLE with `m_we`=0; no `done`; RAM[dst+2..] unchanged.
- With `DBUS_DMA_FILL_EN`: fill=1, fill_val=16'hA5A5, dst=16'h0020, len=3 → 3 consecutive write cycles; RAM[0x20..0x22]=A5A5; `done` at T+4.
